// File: rtl/imm_encoder.sv
// Immediate encoder: overlays a signed immediate into the bit fields of an RV32I
// instruction template, flags unrepresentable immediates, two-stage valid/ready pipeline.
module imm_encoder #(
    parameter int ERR_CNT_W   = 8,
    parameter int CHECK_RANGE = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2:0]           in_ImmSrc,
    input  logic [31:0]          in_imm,
    input  logic [31:0]          in_tmpl,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [31:0]          out_instr,
    output logic                 out_err,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    localparam logic [2:0] SRC_I = 3'b000;
    localparam logic [2:0] SRC_S = 3'b001;
    localparam logic [2:0] SRC_B = 3'b010;
    localparam logic [2:0] SRC_J = 3'b011;
    localparam logic [2:0] SRC_U = 3'b100;

    // Scatter the immediate into the format's fields; unlisted bits keep the template.
    function automatic logic [31:0] pack_word(input logic [2:0] src,
                                              input logic signed [31:0] m,
                                              input logic [31:0] t);
        logic [31:0] r;
        case (src)
            SRC_I:   r = {m[11:0], t[19:0]};
            SRC_S:   r = {m[11:5], t[24:12], m[4:0], t[6:0]};
            SRC_B:   r = {m[12], m[10:5], t[24:12], m[4:1], m[11], t[6:0]};
            SRC_J:   r = {m[20], m[10:1], m[11], m[19:12], t[11:0]};
            SRC_U:   r = {m[31:12], t[11:0]};
            default: r = t;
        endcase
        return r;
    endfunction

    function automatic logic imm_error(input logic [2:0] src,
                                       input logic signed [31:0] m);
        logic e;
        case (src)
            SRC_I, SRC_S: e = (m < -32'sd2048) || (m > 32'sd2047);
            SRC_B:        e = (m < -32'sd4096) || (m > 32'sd4094) || m[0];
            SRC_J:        e = (m < -32'sd1048576) || (m > 32'sd1048574) || m[0];
            SRC_U:        e = (m[11:0] != 12'd0);
            default:      e = 1'b1;
        endcase
        return (CHECK_RANGE != 0) ? e : 1'b0;
    endfunction

    function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] c);
        return (&c) ? c : c + ERR_CNT_W'(1);
    endfunction

    logic                  vld_p1;
    logic [2:0]            src_p1;
    logic signed [31:0]    imm_p1;
    logic [31:0]           tmpl_p1;
    logic [31:0]           instr_p1;
    logic                  err_p1;

    logic                  vld_p2;
    logic [31:0]           instr_p2;
    logic                  err_p2;
    logic [ERR_CNT_W-1:0]  err_cnt_p2;

    logic                  s1_load;
    logic                  s2_load;

    // out_ready reaches in_ready combinationally so a full pipe still streams 1 word/cycle.
    assign s2_load  = !vld_p2 || out_ready;
    assign s1_load  = !vld_p1 || s2_load;
    assign in_ready = s1_load;

    // ---- S1: register raw inputs ----
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p1 <= 1'b0;
        end else if (s1_load) begin
            vld_p1 <= in_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (s1_load && in_valid) begin
            src_p1  <= in_ImmSrc;
            imm_p1  <= in_imm;
            tmpl_p1 <= in_tmpl;
        end
    end

    always_comb begin
        instr_p1 = pack_word(src_p1, imm_p1, tmpl_p1);
        err_p1   = imm_error(src_p1, imm_p1);
    end

    // ---- S2: packed word, error flag and error counter ----
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p2     <= 1'b0;
            instr_p2   <= 32'd0;
            err_p2     <= 1'b0;
            err_cnt_p2 <= '0;
        end else if (s2_load) begin
            vld_p2 <= vld_p1;
            if (vld_p1) begin
                instr_p2 <= instr_p1;
                err_p2   <= err_p1;
                if (err_p1) begin
                    err_cnt_p2 <= sat_inc(err_cnt_p2);
                end
            end
        end
    end

    assign out_valid = vld_p2;
    assign out_instr = instr_p2;
    assign out_err   = err_p2;
    assign err_cnt   = err_cnt_p2;

endmodule

// File: tb/tb_imm_encoder.sv
// Scoreboard bench for imm_encoder: randomized and directed words checked against a
// mask/shift reference model, with an independent field-decoding round-trip check.
module tb_imm_encoder;

    localparam int W      = 8;
    localparam int CNTMAX = (1 << W) - 1;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [2:0]   in_ImmSrc;
    logic [31:0]  in_imm;
    logic [31:0]  in_tmpl;
    logic         out_valid;
    logic         out_ready;
    logic [31:0]  out_instr;
    logic         out_err;
    logic [W-1:0] err_cnt;

    imm_encoder #(.ERR_CNT_W(W), .CHECK_RANGE(1)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_ImmSrc(in_ImmSrc), .in_imm(in_imm), .in_tmpl(in_tmpl),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_err(out_err), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] instr;
        logic        err;
        logic [2:0]  src;
        logic [31:0] imm;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   pushed   = 0;
    int   popped   = 0;
    int   errs     = 0;
    int   rdy_mode = 0;
    logic [31:0] cur_exp_instr;
    logic        cur_exp_err;

    task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %h, expected %h at %0t", name, act, expv, $time);
    endtask

    // Reference: field placement by masks and shifts, errors by integer ranges.
    function automatic logic [32:0] model(input logic [2:0] s, input logic [31:0] m, input logic [31:0] t);
        logic [31:0] r;
        logic        e;
        int          v;
        v = $signed(m);
        case (s)
            3'd0: begin
                r = (t & 32'h000FFFFF) | ((m & 32'hFFF) << 20);
                e = (v < -2048) || (v > 2047);
            end
            3'd1: begin
                r = (t & ~32'hFE000F80) | (((m >> 5) & 32'h7F) << 25) | ((m & 32'h1F) << 7);
                e = (v < -2048) || (v > 2047);
            end
            3'd2: begin
                r = (t & ~32'hFE000F80) | (((m >> 12) & 32'h1) << 31) | (((m >> 5) & 32'h3F) << 25)
                  | (((m >> 1) & 32'hF) << 8) | (((m >> 11) & 32'h1) << 7);
                e = (v < -4096) || (v > 4094) || ((v % 2) != 0);
            end
            3'd3: begin
                r = (t & 32'h00000FFF) | (((m >> 20) & 32'h1) << 31) | (((m >> 1) & 32'h3FF) << 21)
                  | (((m >> 11) & 32'h1) << 20) | (m & 32'h000FF000);
                e = (v < -1048576) || (v > 1048574) || ((v % 2) != 0);
            end
            3'd4: begin
                r = (t & 32'h00000FFF) | (m & 32'hFFFFF000);
                e = (m & 32'hFFF) != 0;
            end
            default: begin
                r = t;
                e = 1'b1;
            end
        endcase
        return {e, r};
    endfunction

    function automatic logic [31:0] sext(input logic [31:0] raw, input int n);
        logic [31:0] r;
        r = raw;
        if (raw[n-1]) r = raw | (32'hFFFFFFFF << n);
        return r;
    endfunction

    // Immediate extender (what the core's decoder does), used for the round-trip invariant.
    function automatic logic [31:0] extend(input logic [31:0] x, input logic [2:0] s);
        case (s)
            3'd0: return sext(x >> 20, 12);
            3'd1: return sext(((x >> 25) << 5) | ((x >> 7) & 32'h1F), 12);
            3'd2: return sext(((x >> 31) << 12) | (((x >> 7) & 32'h1) << 11)
                            | (((x >> 25) & 32'h3F) << 5) | (((x >> 8) & 32'hF) << 1), 13);
            3'd3: return sext(((x >> 31) << 20) | (x & 32'h000FF000)
                            | (((x >> 20) & 32'h1) << 11) | (((x >> 21) & 32'h3FF) << 1), 21);
            3'd4: return x & 32'hFFFFF000;
            default: return 32'd0;
        endcase
    endfunction

    // Monitor and scoreboard; handshakes seen here complete on the next rising edge.
    always @(negedge clk) begin
        exp_t e;
        int   exp_cnt;
        logic exp_rdy;
        if (reset) begin
            q.delete();
            pushed = 0;
            popped = 0;
            errs   = 0;
        end else begin
            exp_rdy = !((pushed - popped) == 2 && !out_ready);
            chk(in_ready == exp_rdy, "in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
            if (out_valid) begin
                if (q.size() == 0) begin
                    chk(1'b0, "spurious_out_valid", out_instr, 32'd0);
                end else begin
                    e = q[0];
                    chk(out_instr == e.instr, "out_instr", out_instr, e.instr);
                    chk(out_err == e.err, "out_err", {31'd0, out_err}, {31'd0, e.err});
                    if (out_ready) begin
                        void'(q.pop_front());
                        popped++;
                        if (e.err) errs++;
                        exp_cnt = (errs > CNTMAX) ? CNTMAX : errs;
                        chk(int'(err_cnt) == exp_cnt, "err_cnt", 32'(err_cnt), 32'(exp_cnt));
                        if (!out_err)
                            chk(extend(out_instr, e.src) == e.imm, "roundtrip", extend(out_instr, e.src), e.imm);
                    end
                end
            end
            if (in_valid && in_ready) begin
                e.instr = cur_exp_instr;
                e.err   = cur_exp_err;
                e.src   = in_ImmSrc;
                e.imm   = in_imm;
                q.push_back(e);
                pushed++;
            end
        end
    end

    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = ~out_ready;
                2:       out_ready = 1'($urandom_range(0, 1));
                default: out_ready = 1'b0;
            endcase
        end
    end

    // Called at posedge+1; returns at posedge+1 after the word was accepted.
    task automatic send_raw(input logic [2:0] s, input logic [31:0] m, input logic [31:0] t,
                            input logic [31:0] ei, input logic ee);
        bit acc;
        int n;
        in_valid      = 1'b1;
        in_ImmSrc     = s;
        in_imm        = m;
        in_tmpl       = t;
        cur_exp_instr = ei;
        cur_exp_err   = ee;
        n = 0;
        do begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!acc && n < 200);
        if (!acc) chk(1'b0, "accept_timeout", 32'(n), 32'd200);
        in_valid = 1'b0;
    endtask

    task automatic send(input logic [2:0] s, input logic [31:0] m, input logic [31:0] t);
        logic [32:0] r;
        r = model(s, m, t);
        send_raw(s, m, t, r[31:0], r[32]);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (q.size() != 0) chk(1'b0, "drain_timeout", 32'(q.size()), 32'd0);
    endtask

    function automatic logic [31:0] rand_imm();
        logic [31:0] m;
        case ($urandom_range(0, 3))
            0:       m = $urandom;
            1:       m = 32'(int'($urandom_range(0, 10000)) - 5000);
            2:       m = 32'(int'($urandom_range(0, 4200000)) - 2100000);
            default: m = $urandom & 32'hFFFFF000;
        endcase
        if ($urandom_range(0, 1) == 1) m[0] = 1'b0;
        return m;
    endfunction

    function automatic logic [2:0] rand_src();
        return ($urandom_range(0, 9) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
    endfunction

    initial begin
        int base;
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_ImmSrc = 3'd0;
        in_imm    = 32'd0;
        in_tmpl   = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        chk(out_valid == 1'b0, "reset_out_valid", {31'd0, out_valid}, 32'd0);
        chk(out_instr == 32'd0, "reset_out_instr", out_instr, 32'd0);
        chk(out_err == 1'b0, "reset_out_err", {31'd0, out_err}, 32'd0);
        chk(err_cnt == '0, "reset_err_cnt", 32'(err_cnt), 32'd0);
        reset = 1'b0;
        #1;
        chk(in_ready == 1'b1, "in_ready_after_reset", {31'd0, in_ready}, 32'd1);

        // Directed vectors with values worked out by hand, plus latency.
        send_raw(3'd0, 32'hFFFFFFFF, 32'h00000013, 32'hFFF00013, 1'b0);
        chk(out_valid == 1'b0, "latency_n1", {31'd0, out_valid}, 32'd0);
        @(posedge clk);
        #1;
        chk(out_valid == 1'b1, "latency_n2", {31'd0, out_valid}, 32'd1);
        send_raw(3'd2, 32'hFFFFF000, 32'h00000063, 32'h80000063, 1'b0);
        send_raw(3'd2, 32'd4095,     32'h00000063, 32'h7E000FE3, 1'b1);
        drain();
        chk(err_cnt == W'(1), "err_cnt_after_b", 32'(err_cnt), 32'd1);
        send_raw(3'd3, 32'd2048,      32'h0000006F, 32'h0010006F, 1'b0);
        send_raw(3'd4, 32'h12345000,  32'h00000037, 32'h12345037, 1'b0);
        send_raw(3'd4, 32'h12345001,  32'h00000037, 32'h12345037, 1'b1);
        send_raw(3'd7, 32'h00000555,  32'hDEADBEEF, 32'hDEADBEEF, 1'b1);
        drain();
        chk(err_cnt == W'(3), "err_cnt_after_u_ill", 32'(err_cnt), 32'd3);

        // Range boundaries on each format.
        send(3'd0, 32'd2047, $urandom);        send(3'd0, -32'sd2048, $urandom);
        send(3'd0, 32'd2048, $urandom);        send(3'd1, -32'sd2049, $urandom);
        send(3'd1, -32'sd2048, $urandom);      send(3'd2, 32'd4094, $urandom);
        send(3'd2, 32'd4096, $urandom);        send(3'd2, -32'sd4098, $urandom);
        send(3'd3, 32'd1048574, $urandom);     send(3'd3, 32'd1048576, $urandom);
        send(3'd3, -32'sd1048576, $urandom);   send(3'd3, -32'sd1048578, $urandom);
        send(3'd3, 32'd3, $urandom);           send(3'd4, 32'hFFFFF800, $urandom);
        drain();

        // Backpressure: 8 words with out_ready toggling.
        rdy_mode = 1;
        base = popped;
        for (int i = 0; i < 8; i++) send(3'($urandom_range(0, 4)), rand_imm(), $urandom);
        drain();
        chk(popped - base == 8, "backpressure_count", 32'(popped - base), 32'd8);

        // Random traffic with random downstream stalls and input gaps.
        rdy_mode = 2;
        for (int i = 0; i < 200; i++) begin
            send(rand_src(), rand_imm(), $urandom);
            if ($urandom_range(0, 4) == 0) begin
                @(posedge clk);
                #1;
            end
        end
        drain();

        // Reset with two words in flight.
        rdy_mode = 3;
        @(posedge clk);
        #1;
        send(3'd7, 32'd1, $urandom);
        send(3'd0, 32'd5, $urandom);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk(out_valid == 1'b0, "midreset_out_valid", {31'd0, out_valid}, 32'd0);
        chk(err_cnt == '0, "midreset_err_cnt", 32'(err_cnt), 32'd0);
        reset    = 1'b0;
        rdy_mode = 0;
        @(posedge clk);
        #1;
        send(3'd1, -32'sd7, 32'h00002023);
        drain();
        chk(popped == 1, "post_reset_flow", 32'(popped), 32'd1);

        // Error counter saturation.
        for (int i = 0; i < 300; i++) send(3'($urandom_range(5, 7)), $urandom, $urandom);
        drain();
        chk(int'(err_cnt) == CNTMAX, "err_cnt_saturated", 32'(err_cnt), 32'(CNTMAX));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
